// File: rtl/spi_command_scheduler_if.sv
// Bundle of the SPI-receiver, Avalon-MM master and response-channel signals
// around the command scheduler. master = scheduler side, slave = environment side.
interface spi_command_scheduler_if;
  logic [5:0]  io_Command;
  logic [31:0] io_CommandArgument;
  logic        io_ArgumentReadFinished;
  logic [31:0] io_Avalon_address;
  logic        io_Avalon_read;
  logic        io_Avalon_write;
  logic [31:0] io_Avalon_writedata;
  logic [31:0] io_Avalon_readdata;
  logic        io_Avalon_waitrequest;
  logic        io_Resp_valid;
  logic        io_Resp_ready;
  logic [7:0]  io_Resp_r1;
  logic [31:0] io_Resp_data;
  logic        io_Overflow;

  modport master (
    input  io_Command, io_CommandArgument, io_ArgumentReadFinished,
           io_Avalon_readdata, io_Avalon_waitrequest, io_Resp_ready,
    output io_Avalon_address, io_Avalon_read, io_Avalon_write, io_Avalon_writedata,
           io_Resp_valid, io_Resp_r1, io_Resp_data, io_Overflow
  );

  modport slave (
    output io_Command, io_CommandArgument, io_ArgumentReadFinished,
           io_Avalon_readdata, io_Avalon_waitrequest, io_Resp_ready,
    input  io_Avalon_address, io_Avalon_read, io_Avalon_write, io_Avalon_writedata,
           io_Resp_valid, io_Resp_r1, io_Resp_data, io_Overflow
  );
endinterface

// File: rtl/spi_command_scheduler.sv
// Queues SPI-received commands, executes them on an Avalon-MM master port and
// returns an SD-style R1 response (plus read data for CMD17).
module spi_command_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic                     clock,
  input logic                     reset,
  spi_command_scheduler_if.master sif
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [15:0]     STALL_MAX = 16'(TIMEOUT - 1);
  localparam logic [5:0]      CMD0  = 6'd0,  CMD1  = 6'd1,  CMD17 = 6'd17,
                              CMD24 = 6'd24, CMD41 = 6'd41, CMD55 = 6'd55;

  typedef struct packed {
    logic [5:0]  cmd;
    logic [31:0] arg;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUS, S_RESP} state_t;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        hist;
  logic        push, pop, empty, full;
  cmd_t        head;
  state_t      state;
  logic [5:0]  cur_cmd;
  logic        idle_f, app_f;
  logic [15:0] stall_cnt;
  logic [31:0] av_addr, av_wdata, resp_data;
  logic        av_rd, av_wr, resp_valid, ovf;
  logic [7:0]  resp_r1;

  assign push  = sif.io_ArgumentReadFinished & ~hist;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == S_IDLE) && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign sif.io_Avalon_address   = av_addr;
  assign sif.io_Avalon_read      = av_rd;
  assign sif.io_Avalon_write     = av_wr;
  assign sif.io_Avalon_writedata = av_wdata;
  assign sif.io_Resp_valid       = resp_valid;
  assign sif.io_Resp_r1          = resp_r1;
  assign sif.io_Resp_data        = resp_data;
  assign sif.io_Overflow         = ovf;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  always_ff @(posedge clock)
    if (push && (!full || pop))
      mem[wr_ptr[AW-1:0]] <= '{cmd: sif.io_Command, arg: sif.io_CommandArgument};

  always_ff @(posedge clock) begin
    if (reset) begin
      hist       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf        <= 1'b0;
      state      <= S_IDLE;
      cur_cmd    <= '0;
      idle_f     <= 1'b1;
      app_f      <= 1'b0;
      stall_cnt  <= '0;
      av_addr    <= '0;
      av_wdata   <= '0;
      av_rd      <= 1'b0;
      av_wr      <= 1'b0;
      resp_valid <= 1'b0;
      resp_r1    <= '0;
      resp_data  <= '0;
    end else begin
      hist <= sif.io_ArgumentReadFinished;
      if (push && (!full || pop)) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push && full && !pop)   ovf    <= 1'b1;

      case (state)
        S_IDLE: if (!empty) begin
          rd_ptr  <= rd_ptr + (AW+1)'(1);
          cur_cmd <= head.cmd;
          if (head.cmd == CMD17 || head.cmd == CMD24) begin
            app_f     <= 1'b0;
            stall_cnt <= '0;
            state     <= S_BUS;
            if (head.cmd == CMD17) begin
              av_rd   <= 1'b1;
              av_addr <= head.arg;
            end else begin
              av_wr    <= 1'b1;
              av_addr  <= {16'h0, head.arg[31:16]};
              av_wdata <= {16'h0, head.arg[15:0]};
            end
          end else begin
            state <= S_EXEC;
          end
        end

        // Flag-only commands spend one cycle here so every command has the same latency.
        S_EXEC: begin
          app_f      <= 1'b0;
          resp_data  <= '0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
          if (cur_cmd == CMD0) begin
            idle_f  <= 1'b1;
            resp_r1 <= 8'h01;
          end else if (cur_cmd == CMD1 || (cur_cmd == CMD41 && app_f)) begin
            idle_f  <= 1'b0;
            resp_r1 <= 8'h00;
          end else if (cur_cmd == CMD55) begin
            app_f   <= 1'b1;
            resp_r1 <= {7'b0, idle_f};
          end else begin
            resp_r1 <= 8'h04 | {7'b0, idle_f};
          end
        end

        S_BUS: begin
          if (!sif.io_Avalon_waitrequest) begin
            av_rd      <= 1'b0;
            av_wr      <= 1'b0;
            resp_r1    <= {7'b0, idle_f};
            resp_data  <= (cur_cmd == CMD17) ? sif.io_Avalon_readdata : 32'h0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (stall_cnt == STALL_MAX) begin
            av_rd      <= 1'b0;
            av_wr      <= 1'b0;
            resp_r1    <= 8'h40 | {7'b0, idle_f};
            resp_data  <= '0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end

        S_RESP: if (sif.io_Resp_ready) begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_command_scheduler.sv
// Directed + randomized bench for spi_command_scheduler; expectations come from a
// command-level model of the SD flag/R1 rules and an Avalon slave driven in-line.
module tb_spi_command_scheduler;
  localparam int DEP = 4;
  localparam int TMO = 255;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  spi_command_scheduler_if bus();

  spi_command_scheduler #(.DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .sif   (bus)
  );

  always #5 clock = ~clock;

  // model state
  bit          m_idle = 1'b1;
  bit          m_app  = 1'b0;
  // slave behaviour and observed bus activity
  int          ws_cur  = 0;
  logic [31:0] rdv_cur = '0;
  logic        b_rd, b_wr, b_bad;
  logic [31:0] b_addr, b_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 = no bus, 1 = read, 2 = write
  function automatic void model(input logic [5:0] c, input bit tmo,
                                output logic [7:0] r1, output int kind);
    kind = 0;
    case (c)
      6'd0:  begin m_idle = 1'b1; m_app = 1'b0; r1 = 8'h01; end
      6'd1:  begin m_idle = 1'b0; m_app = 1'b0; r1 = 8'h00; end
      6'd41: begin
        if (m_app) begin m_idle = 1'b0; r1 = 8'h00; end
        else r1 = 8'h04 | {7'b0, m_idle};
        m_app = 1'b0;
      end
      6'd55: begin m_app = 1'b1; r1 = {7'b0, m_idle}; end
      6'd17, 6'd24: begin
        m_app = 1'b0;
        kind  = (c == 6'd17) ? 1 : 2;
        r1    = (tmo ? 8'h40 : 8'h00) | {7'b0, m_idle};
      end
      default: begin m_app = 1'b0; r1 = 8'h04 | {7'b0, m_idle}; end
    endcase
  endfunction

  task automatic pulse(input logic [5:0] c, input logic [31:0] a);
    @(negedge clock);
    bus.io_Command = c;
    bus.io_CommandArgument = a;
    bus.io_ArgumentReadFinished = 1'b1;
    @(negedge clock);
    bus.io_ArgumentReadFinished = 1'b0;
  endtask

  // Acts as the Avalon slave until a response shows up or the budget expires.
  task automatic service(input int limit, output int cyc, output int hold);
    cyc = 0; hold = 0;
    b_rd = 0; b_wr = 0; b_bad = 0; b_addr = '0; b_wd = '0;
    while (!bus.io_Resp_valid && cyc < limit) begin
      if (bus.io_Avalon_read || bus.io_Avalon_write) begin
        if (hold == 0) begin
          b_rd = bus.io_Avalon_read; b_wr = bus.io_Avalon_write;
          b_addr = bus.io_Avalon_address; b_wd = bus.io_Avalon_writedata;
        end else if (b_rd !== bus.io_Avalon_read || b_wr !== bus.io_Avalon_write ||
                     b_addr !== bus.io_Avalon_address || b_wd !== bus.io_Avalon_writedata)
          b_bad = 1;
        if (bus.io_Avalon_read && bus.io_Avalon_write) b_bad = 1;
        hold++;
        bus.io_Avalon_waitrequest = (hold <= ws_cur);
        bus.io_Avalon_readdata = rdv_cur;
      end else begin
        bus.io_Avalon_waitrequest = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bus.io_Avalon_waitrequest = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [7:0] er1, input logic [31:0] edata);
    chk({tag, ".valid"}, bus.io_Resp_valid, 1);
    chk({tag, ".r1"}, bus.io_Resp_r1, er1);
    chk({tag, ".data"}, bus.io_Resp_data, edata);
    repeat ($urandom_range(1, 3)) @(negedge clock);
    chk({tag, ".valid_held"}, bus.io_Resp_valid, 1);
    chk({tag, ".r1_held"}, bus.io_Resp_r1, er1);
    bus.io_Resp_ready = 1'b1;
    @(negedge clock);
    bus.io_Resp_ready = 1'b0;
    chk({tag, ".valid_drop"}, bus.io_Resp_valid, 0);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] c, input logic [31:0] a,
                         input int ws, input logic [31:0] rdv);
    logic [7:0]  er1;
    logic [31:0] edata;
    int          kind, cyc, hold;
    bit          tmo;
    tmo = (ws >= TMO);
    model(c, tmo, er1, kind);
    edata   = (kind == 1 && !tmo) ? rdv : 32'h0;
    ws_cur  = ws;
    rdv_cur = rdv;
    pulse(c, a);
    service(TMO + 20, cyc, hold);
    chk({tag, ".latency"}, cyc, kind == 0 ? 2 : (tmo ? 1 + TMO : 2 + ws));
    chk({tag, ".bus_cycles"}, hold, kind == 0 ? 0 : (tmo ? TMO : 1 + ws));
    if (kind != 0) begin
      chk({tag, ".kind"}, {30'b0, b_wr, b_rd}, kind == 1 ? 32'd1 : 32'd2);
      chk({tag, ".addr"}, b_addr, kind == 1 ? a : {16'h0, a[31:16]});
      if (kind == 2) chk({tag, ".wdata"}, b_wd, {16'h0, a[15:0]});
      chk({tag, ".bus_stable"}, b_bad, 0);
    end
    check_resp(tag, er1, edata);
  endtask

  initial begin
    logic [5:0]  ocmd [6];
    logic [7:0]  oexp [$];
    logic [7:0]  r1tmp;
    logic [5:0]  rc;
    logic [5:0]  pick [8];
    int          kind, cyc, hold;

    bus.io_Command = '0;
    bus.io_CommandArgument = '0;
    bus.io_ArgumentReadFinished = 1'b1;
    bus.io_Avalon_readdata = '0;
    bus.io_Avalon_waitrequest = 1'b0;
    bus.io_Resp_ready = 1'b0;
    reset = 1'b1;

    // level held high through reset is not a command
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst.valid", bus.io_Resp_valid, 0);
    chk("rst.read", bus.io_Avalon_read, 0);
    chk("rst.write", bus.io_Avalon_write, 0);
    chk("rst.addr", bus.io_Avalon_address, 0);
    chk("rst.wdata", bus.io_Avalon_writedata, 0);
    chk("rst.r1", bus.io_Resp_r1, 0);
    chk("rst.data", bus.io_Resp_data, 0);
    chk("rst.ovf", bus.io_Overflow, 0);
    bus.io_ArgumentReadFinished = 1'b0;
    repeat (2) @(negedge clock);

    run_cmd("cmd0", 6'd0, 32'h0, 0, 32'h0);
    run_cmd("cmd1", 6'd1, 32'h0, 0, 32'h0);
    run_cmd("cmd0b", 6'd0, 32'h0, 0, 32'h0);
    run_cmd("cmd17", 6'd17, 32'h0000_0010, 3, 32'hDEAD_BEEF);
    run_cmd("cmd24", 6'd24, 32'h0003_ABCD, 0, 32'h0);

    // overflow: first command parks in RESP, DEPTH queue, the rest dropped
    ocmd = '{6'd0, 6'd55, 6'd41, 6'd8, 6'd1, 6'd0};
    for (int i = 0; i < 6; i++) begin
      if (i < 1 + DEP) begin
        model(ocmd[i], 1'b0, r1tmp, kind);
        oexp.push_back(r1tmp);
      end
      pulse(ocmd[i], 32'(i));
    end
    @(negedge clock);
    chk("ovf.set", bus.io_Overflow, 1);
    for (int i = 0; i < 1 + DEP; i++) begin
      service(20, cyc, hold);
      check_resp($sformatf("ovf.drain%0d", i), oexp.pop_front(), 32'h0);
    end
    repeat (8) @(negedge clock);
    chk("ovf.no_extra", bus.io_Resp_valid, 0);
    chk("ovf.sticky", bus.io_Overflow, 1);

    run_cmd("timeout", 6'd17, 32'h0000_0100, 100000, 32'h1234_5678);
    run_cmd("cmd55", 6'd55, 32'h0, 0, 32'h0);
    run_cmd("acmd41", 6'd41, 32'h0, 0, 32'h0);
    run_cmd("cmd0c", 6'd0, 32'h0, 0, 32'h0);
    run_cmd("cmd41_noapp", 6'd41, 32'h0, 0, 32'h0);

    pick = '{6'd0, 6'd1, 6'd17, 6'd24, 6'd41, 6'd55, 6'd8, 6'd17};
    for (int i = 0; i < 40; i++) begin
      rc = (i % 5 == 4) ? 6'($urandom_range(0, 63)) : pick[$urandom_range(0, 7)];
      run_cmd($sformatf("rnd%0d", i), rc, $urandom, $urandom_range(0, 5), $urandom);
    end

    // reset while a read is stalled
    ws_cur = 100000;
    pulse(6'd17, 32'h0000_0040);
    service(4, cyc, hold);
    chk("midrst.read_before", bus.io_Avalon_read, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst.read", bus.io_Avalon_read, 0);
    chk("midrst.write", bus.io_Avalon_write, 0);
    chk("midrst.valid", bus.io_Resp_valid, 0);
    chk("midrst.ovf", bus.io_Overflow, 0);
    reset = 1'b0;
    m_idle = 1'b1;
    m_app  = 1'b0;
    @(negedge clock);
    run_cmd("post_rst", 6'd13, 32'h0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_command_scheduler.md
# spi_command_scheduler

Sequences commands delivered by the SPI slave receiver (6-bit command index, 32-bit argument, "argument read finished" level) onto an Avalon-MM master port and returns an SD-style R1 response with optional read data. It sits between the SPI slave receiver front end and the system interconnect. It buffers up to DEPTH commands so back-to-back SPI frames are not lost while a bus transfer is stalled.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max cycles an Avalon transfer may stall before abort (1..65535)
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  reset, synchronous, active-high
- io_Command  in  6  command index from SPI receiver
- io_CommandArgument  in  32  command argument
- io_ArgumentReadFinished  in  1  level; rising edge marks a new complete command
- io_Avalon_address  out  32  master address
- io_Avalon_read  out  1  master read request
- io_Avalon_write  out  1  master write request
- io_Avalon_writedata  out  32  master write data
- io_Avalon_readdata  in  32  slave read data, valid on completing cycle
- io_Avalon_waitrequest  in  1  slave stall
- io_Resp_valid  out  1  response available
- io_Resp_ready  in  1  response consumer accepts
- io_Resp_r1  out  8  R1 status byte
- io_Resp_data  out  32  read data (CMD17), else 0
- io_Overflow  out  1  sticky: a command was dropped because FIFO full

## Operation
- Edge detect: history register, reset value 1; push when io_ArgumentReadFinished=1 and history=0. A level held high across reset is not a command.
- FIFO entry = {command, argument}, 38 bits. Push when full and no pop in the same cycle: drop the command and set io_Overflow. io_Overflow clears only on reset. Push and pop in the same cycle is legal at any occupancy.
- idle flag, reset 1: R1 bit0 = idle flag after command execution.
- app flag, reset 0: set by CMD55, cleared by any other command.
- Decode per popped command:
  - CMD0: set idle, R1=0x01, no bus.
  - CMD1, or CMD41 with app=1: clear idle, R1=0x00, no bus.
  - CMD55: set app, R1={7'b0,idle}, no bus.
  - CMD17: Avalon read, address=argument, R1={7'b0,idle}, data=readdata.
  - CMD24: Avalon write, address={16'b0,arg[31:16]}, writedata={16'b0,arg[15:0]}, R1={7'b0,idle}.
  - Anything else (including CMD41 with app=0): R1=0x04|idle, no bus.
- FSM states and transitions:
  - IDLE → BUS or RESP: on pop when FIFO non-empty.
  - BUS → RESP: the cycle io_Avalon_waitrequest=0 completes the transfer; io_Avalon_readdata is captured that cycle.
  - BUS timeout: the stall counter reaches TIMEOUT with waitrequest still 1 → drop read/write, R1=0x40|idle, data=0, go to RESP.
  - RESP → IDLE: when io_Resp_valid & io_Resp_ready.
- Avalon request signals are held stable for the whole BUS state; read and write are never both 1.

## Timing
- Reset values: address 0, read 0, write 0, writedata 0, Resp_valid 0, r1 0, data 0, Overflow 0. FIFO is empty, FSM is in IDLE.
- Edge sampled at clock edge k → entry in FIFO after k → popped at k+1 → bus request visible after k+1.
- With zero wait states: transfer completes at k+2 and io_Resp_valid is high after k+2.
- Non-bus commands: io_Resp_valid is high after k+2.
- Each waitrequest cycle adds one cycle of latency; the stall counter counts cycles in BUS with waitrequest=1.
- io_Resp_* are registered and held stable while valid and not ready.
- Throughput: one command per 3 cycles with ready tied high and zero wait states. The FIFO absorbs bursts.
- Reset mid-BUS: read/write deassert after the reset edge. The in-flight response and FIFO contents are discarded.

## Test plan
- Reset held with ArgumentReadFinished=1, then released at the same level → no push; outputs at reset values; Overflow=0.
- CMD0 arg 0, then CMD1 → R1 0x01, then 0x00; no Avalon activity; valid appears 2 cycles after each edge.
- CMD17 arg 0x00000010, slave waitrequest for 3 cycles, readdata 0xDEADBEEF → address 0x10, read held 4 cycles, R1 0x01, data 0xDEADBEEF.
- CMD24 arg 0x0003ABCD with waitrequest=0 → write for 1 cycle, address 0x3, writedata 0xABCD, R1 reflects idle flag.
- io_Resp_ready=0, six command edges, DEPTH=4 → first response stalls in RESP; 4 commands queued, 1 dropped, Overflow=1. After ready=1, responses drain in order.
- CMD17 with waitrequest stuck at 1 and TIMEOUT=255 → read drops after 255 stall cycles, R1=0x40|idle, data 0. CMD55 then CMD41 → idle cleared. CMD41 alone → R1 0x05.
